demux_dispatcher: RTL and testbench
===================================

DEMUX_DISPATCHER -- requirements
Module: demux_dispatcher

Interface
REQ-001 Parameter DW, default 8, sets the width of the data word carried from input to all eight outputs.
REQ-002 Parameter TIMEOUT, default 16, sets the number of SEND cycles without out_ready before the held word is dropped; legal range 1..255.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port in_data, input, DW, the word to be dispatched.
REQ-006 Port in_valid, input, 1, in_data is valid this cycle.
REQ-007 Port in_ready, output, 1, the block accepts in_data this cycle.
REQ-008 Port mode, input, 1, 0 = round-robin over enabled channels, 1 = fixed channel fix_sel.
REQ-009 Port fix_sel, input, 3, the target channel when mode=1.
REQ-010 Port chan_en, input, 8, per-channel enable mask; bit i set = channel i eligible.
REQ-011 Port out_data, output, DW, the held word, common to all channels.
REQ-012 Port out_valid, output, 8, one-hot; bit i = word offered to channel i.
REQ-013 Port out_ready, input, 8, per-channel sink ready.
REQ-014 Port cur_sel, output, 3, channel of the word currently held or last sent.
REQ-015 Port drop_cnt, output, 8, saturating count of words dropped on timeout.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-017 In IDLE, in_ready SHALL be 1 only if an eligible target exists:
- mode=0: chan_en != 0
- mode=1: chan_en[fix_sel] = 1
REQ-018 In SEND, in_ready SHALL be 0.
REQ-019 When IDLE, in_valid=1 and in_ready=1, the block SHALL:
- capture in_data into the hold register
- compute the target
- enter SEND on the next cycle
REQ-020 Target computation:
- mode=1: the target is fix_sel.
- mode=0: the target is the first set chan_en bit found searching upward from rr_ptr, wrapping 7 -> 0.
REQ-021 The target, mode and data SHALL be frozen at capture; changes to chan_en, mode or fix_sel during SEND have no effect on the held word.
REQ-022 In SEND, out_valid SHALL be one-hot at bit cur_sel, and out_data SHALL equal the held word.
REQ-023 In IDLE, out_valid SHALL be 8'h00; out_data SHALL hold its last value.
REQ-024 A transfer occurs in SEND when out_ready[cur_sel]=1; out_ready bits of other channels SHALL be ignored.
REQ-025 On transfer, the block SHALL return to IDLE next cycle, and in mode=0 only, rr_ptr SHALL become (cur_sel+1) mod 8.
REQ-026 Minimum latency from input accept to out_valid SHALL be 1 cycle; peak throughput SHALL be one word per 2 cycles.
REQ-027 A wait counter SHALL:
- clear on entry to SEND
- increment each SEND cycle without a transfer
REQ-028 When the wait counter reaches TIMEOUT-1 with no transfer in that cycle, the block SHALL:
- drop the word and return to IDLE
- increment drop_cnt, saturating at 255
- advance rr_ptr as on a transfer, in mode=0
REQ-029 If a transfer and the timeout coincide, the transfer SHALL win and drop_cnt SHALL be unchanged.
REQ-030 The IDLE -> SEND -> IDLE path SHALL NOT accept a new word in the cycle a transfer completes (no bypass).

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL set:
- state = IDLE
- rr_ptr = 0, cur_sel = 0
- hold register and out_data = 0
- wait counter = 0, drop_cnt = 0
- out_valid = 8'h00
REQ-032 A reset asserted during SEND SHALL discard the held word without incrementing drop_cnt.
REQ-033 In the cycle after reset is released, in_ready SHALL follow REQ-017.

Verification
REQ-034 Round-robin wrap: mode=0, chan_en=8'hFF, out_ready=8'hFF, send 10 words -> out_valid visits bits 0,1,...,7,0,1; each out_valid appears one cycle after its accept.
REQ-035 Skipping: mode=0, chan_en=8'b1010_0100, send 4 words -> targets 2,5,7,2.
REQ-036 Fixed mode: mode=1, fix_sel=3, chan_en[3]=0 -> in_ready=0; then set chan_en[3]=1 -> the word is accepted, out_valid=8'h08, and rr_ptr is unchanged.
REQ-037 Timeout: TIMEOUT=4, out_ready=0 -> out_valid held exactly 4 cycles, then IDLE and drop_cnt=1. With out_ready[cur_sel] rising in the 4th SEND cycle instead -> transfer and drop_cnt=0.
REQ-038 Frozen target: capture with target 1, then toggle chan_en=0 and raise out_ready[6] only -> out_valid stays 8'h02 and no transfer occurs until out_ready[1]=1.
REQ-039 Reset mid-SEND: assert rst in SEND -> next cycle out_valid=0, state IDLE, drop_cnt unchanged, rr_ptr=0.

Source files
------------

// File: rtl/demux_dispatcher_if.sv
// Handshake bus for demux_dispatcher: one input stream in, eight one-hot output channels out.
// Data is common to all channels; out_valid selects which sink the held word is offered to.
interface demux_dispatcher_if #(
  parameter int DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_dispatcher.sv
// One-word demultiplexer: captures an input word and offers it to one of eight channels,
// chosen round-robin over enabled channels or fixed, dropping it after TIMEOUT idle SEND cycles.
module demux_dispatcher #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  demux_dispatcher_if.slave   bus,
  input  logic                mode,
  input  logic [2:0]          fix_sel,
  input  logic [7:0]          chan_en,
  output logic [2:0]          cur_sel,
  output logic [7:0]          drop_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [DW-1:0] hold;
  logic [2:0]    rr_ptr;
  logic [7:0]    wait_cnt;
  logic          held_mode;
  logic          in_ready_c;
  logic          accept;
  logic          xfer;
  logic          timeout_hit;
  logic          drop;

  // First enabled channel at or above ptr, wrapping 7 -> 0.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [7:0] en);
    logic [2:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && en[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    accept      = 1'b0;
    xfer        = 1'b0;
    timeout_hit = 1'b0;
    drop        = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = mode ? chan_en[fix_sel] : (chan_en != 8'h00);
        accept     = bus.in_valid && in_ready_c;
        if (accept) state_nxt = SEND;
      end
      SEND: begin
        xfer        = bus.out_ready[cur_sel];
        timeout_hit = (wait_cnt == WAIT_LAST);
        drop        = !xfer && timeout_hit;
        if (xfer || timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = hold;
  assign bus.out_valid = (state == SEND) ? (8'h01 << cur_sel) : 8'h00;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 3'd0;
      cur_sel   <= 3'd0;
      // NOTE: the hold register is a single word, and it is reset so out_data is defined at startup.
      hold      <= '0;
      wait_cnt  <= 8'd0;
      drop_cnt  <= 8'd0;
      held_mode <= 1'b0;
    end else begin
      state <= state_nxt;

      // Target, mode and data are frozen here for the whole SEND phase.
      if (accept) begin
        hold      <= bus.in_data;
        cur_sel   <= mode ? fix_sel : rr_pick(rr_ptr, chan_en);
        held_mode <= mode;
        wait_cnt  <= 8'd0;
      end else if (state == SEND && !xfer && !timeout_hit) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      if ((xfer || drop) && !held_mode)
        rr_ptr <= cur_sel + 3'd1;

      if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_demux_dispatcher.sv
// Directed self-checking bench for demux_dispatcher (TIMEOUT=4): round-robin, skipping,
// fixed mode, timeout vs. transfer race, frozen target, reset mid-SEND, drop_cnt saturation.
module tb_demux_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [2:0] fix_sel;
  logic [7:0] chan_en;
  logic [2:0] cur_sel;
  logic [7:0] drop_cnt;

  int checks = 0;
  int passes = 0;

  demux_dispatcher_if #(.DW(8)) bus ();

  demux_dispatcher #(.DW(8), .TIMEOUT(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .mode     (mode),
    .fix_sel  (fix_sel),
    .chan_en  (chan_en),
    .cur_sel  (cur_sel),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_v;
  logic [7:0] seq [4];

  initial begin
    rst           = 1'b1;
    mode          = 1'b0;
    fix_sel       = 3'd0;
    chan_en       = 8'h00;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'h00;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'h00);
    check("rst_out_data",  32'(bus.out_data),  32'h00);
    check("rst_cur_sel",   32'(cur_sel),       32'h0);
    check("rst_drop_cnt",  32'(drop_cnt),      32'h00);
    check("rst_in_ready_noen", 32'(bus.in_ready), 32'h0);
    chan_en = 8'hFF;
    #1;
    check("rst_in_ready_en", 32'(bus.in_ready), 32'h1);

    // Round-robin wrap: 10 words over all channels, always-ready sinks
    bus.out_ready = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      bus.in_data  = 8'(8'h10 + k);
      bus.in_valid = 1'b1;
      step();
      exp_v = 8'h01 << (k % 8);
      check("rr_out_valid", 32'(bus.out_valid), 32'(exp_v));
      check("rr_out_data",  32'(bus.out_data),  32'(8'h10 + k));
      check("rr_busy_ready", 32'(bus.in_ready), 32'h0);
      step();
      check("rr_idle_valid", 32'(bus.out_valid), 32'h00);
    end
    check("idle_holds_data", 32'(bus.out_data), 32'h19);
    bus.in_valid = 1'b0;

    // Skipping over disabled channels; rr_ptr is now 2
    chan_en = 8'b1010_0100;
    seq[0] = 8'h04; seq[1] = 8'h20; seq[2] = 8'h80; seq[3] = 8'h04;
    for (int k = 0; k < 4; k++) begin
      bus.in_data  = 8'(8'hA0 + k);
      bus.in_valid = 1'b1;
      step();
      check("skip_out_valid", 32'(bus.out_valid), 32'(seq[k]));
      step();
    end
    bus.in_valid = 1'b0;

    // Fixed mode: channel 3 disabled blocks input, enabling it lets the word through
    mode    = 1'b1;
    fix_sel = 3'd3;
    #1;
    check("fix_blocked_ready", 32'(bus.in_ready), 32'h0);
    bus.in_data  = 8'h5A;
    bus.in_valid = 1'b1;
    step();
    check("fix_blocked_valid", 32'(bus.out_valid), 32'h00);
    chan_en = 8'b1010_1100;
    #1;
    check("fix_open_ready", 32'(bus.in_ready), 32'h1);
    step();
    check("fix_out_valid", 32'(bus.out_valid), 32'h08);
    check("fix_cur_sel",   32'(cur_sel),       32'h3);
    bus.in_valid = 1'b0;
    step();
    // rr_ptr must still be 3 after the fixed-mode word
    mode         = 1'b0;
    chan_en      = 8'hFF;
    bus.in_valid = 1'b1;
    step();
    check("fix_rr_unchanged", 32'(bus.out_valid), 32'h08);
    bus.in_valid = 1'b0;
    step();

    // Timeout: rr_ptr=4, sinks never ready -> 4 SEND cycles then drop
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("to_held_valid", 32'(bus.out_valid), 32'h10);
      check("to_no_drop_yet", 32'(drop_cnt), 32'h00);
      step();
    end
    check("to_idle_valid", 32'(bus.out_valid), 32'h00);
    check("to_drop_cnt",   32'(drop_cnt),      32'h01);

    // Transfer in the 4th SEND cycle beats the timeout; rr_ptr=5
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    check("race_valid_c4", 32'(bus.out_valid), 32'h20);
    bus.out_ready = 8'h20;
    step();
    check("race_idle_valid", 32'(bus.out_valid), 32'h00);
    check("race_drop_cnt",   32'(drop_cnt),      32'h01);

    // Frozen target: rr_ptr=6, only channel 1 enabled at capture
    bus.out_ready = 8'h00;
    chan_en       = 8'h02;
    bus.in_data   = 8'h77;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("frz_valid_c1", 32'(bus.out_valid), 32'h02);
    chan_en       = 8'h00;
    bus.out_ready = 8'h40;
    step();
    check("frz_valid_c2", 32'(bus.out_valid), 32'h02);
    step();
    check("frz_valid_c3", 32'(bus.out_valid), 32'h02);
    bus.out_ready = 8'h02;
    step();
    check("frz_xfer_idle", 32'(bus.out_valid), 32'h00);
    check("frz_drop_cnt",  32'(drop_cnt),      32'h01);

    // Reset mid-SEND: rr_ptr=2, target channel 2
    chan_en       = 8'hFF;
    bus.out_ready = 8'h00;
    bus.in_data   = 8'h99;
    bus.in_valid  = 1'b1;
    step();
    check("rstsend_valid", 32'(bus.out_valid), 32'h04);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstsend_idle",     32'(bus.out_valid), 32'h00);
    check("rstsend_drop_cnt", 32'(drop_cnt),      32'h00);
    check("rstsend_data",     32'(bus.out_data),  32'h00);
    check("rstsend_ready",    32'(bus.in_ready),  32'h1);
    step();
    check("rstsend_rr_zero", 32'(bus.out_valid), 32'h01);
    bus.out_ready = 8'h01;
    bus.in_valid  = 1'b0;
    step();
    check("rstsend_xfer", 32'(bus.out_valid), 32'h00);

    // drop_cnt saturation: 260 consecutive timeouts, 5 cycles each
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      for (int c = 0; c < 5; c++) step();
      if (k == 100) check("sat_mid",  32'(drop_cnt), 32'd100);
      if (k == 255) check("sat_edge", 32'(drop_cnt), 32'd255);
    end
    check("sat_hold", 32'(drop_cnt), 32'd255);
    bus.in_valid = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
